// File: rtl/tte_pkg.sv
// Shared types and constants for the programmable truth-table engine.
package tte_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } tte_state_e;

  localparam logic MODE_LIVE  = 1'b0;
  localparam logic MODE_SWEEP = 1'b1;

  // Number of truth-table entries for an n-input function.
  function automatic int unsigned depth_of(input int unsigned n_in);
    return 32'(1) << n_in;
  endfunction

endpackage

// File: rtl/sweep_counter.sv
// N-bit up-counter that walks the input space during an exhaustive sweep.
module sweep_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         terminal_c
);

  // Count register: clear wins over enable; wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // Terminal count: last vector of the input space is being applied.
  assign terminal_c = &count;

endmodule

// File: rtl/truth_table_engine.sv
// Serially loadable N-input truth table with live evaluation and minterm sweep.
module truth_table_engine
  import tte_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic            load_bit,
  input  logic            mode,
  input  logic            start,
  input  logic [N_IN-1:0] in_vec,
  output logic            X,
  output logic [N_IN-1:0] sweep_vec,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_count
);

  localparam int unsigned DEPTH = depth_of(N_IN);

  tte_state_e       state_q;
  logic [DEPTH-1:0] table_q;
  logic             start_go_c;
  logic             cnt_en_c;
  logic             terminal_c;

  // Start is honoured only from IDLE in sweep mode and loses to a load.
  assign start_go_c = (state_q == IDLE) && start && !load_en && (mode == MODE_SWEEP);
  assign cnt_en_c   = (state_q == SWEEP);

  sweep_counter #(
    .W (N_IN)
  ) u_sweep_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_go_c),
    .en         (cnt_en_c),
    .count      (sweep_vec),
    .terminal_c (terminal_c)
  );

  // Control FSM, table shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      table_q    <= '0;
      X          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (mode == MODE_LIVE) begin
            X <= table_q[in_vec];
          end
          if (load_en) begin
            table_q <= {table_q[DEPTH-2:0], load_bit};
          end else if (start_go_c) begin
            state_q    <= SWEEP;
            busy       <= 1'b1;
            ones_count <= '0;
          end
        end
        SWEEP: begin
          X          <= table_q[sweep_vec];
          ones_count <= ones_count + (N_IN+1)'(table_q[sweep_vec]);
          if (terminal_c) begin
            state_q <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_engine.sv
// Directed bench for truth_table_engine with N_IN=3.
module tb_truth_table_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic       load_bit;
  logic       mode;
  logic       start;
  logic [2:0] in_vec;
  logic       X;
  logic [2:0] sweep_vec;
  logic       busy;
  logic       done;
  logic [3:0] ones_count;

  int n_tests = 0;
  int n_fail  = 0;

  truth_table_engine #(
    .N_IN (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_bit   (load_bit),
    .mode       (mode),
    .start      (start),
    .in_vec     (in_vec),
    .X          (X),
    .sweep_vec  (sweep_vec),
    .busy       (busy),
    .done       (done),
    .ones_count (ones_count)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift a full table in, table[7] first.
  task automatic load_table(input logic [7:0] t);
    mode = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      load_en  = 1'b1;
      load_bit = t[i];
      step();
    end
    load_en  = 1'b0;
    load_bit = 1'b0;
  endtask

  // Evaluate every live input and compare X with the expected table entry.
  task automatic live_all(input string tag, input logic [7:0] t);
    mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_vec = 3'(i);
      step();
      check(tag, 32'(X), 32'(t[i]));
    end
  endtask

  // Run one sweep; optionally disturb inputs while busy.
  task automatic run_sweep(input string tag, input logic [7:0] t, input logic [3:0] exp_ones,
                           input bit disturb);
    mode  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check({tag, "_vec"}, 32'(sweep_vec), 32'(k));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      if (disturb) begin
        load_en  = 1'b1;
        load_bit = k[0];
        mode     = (k >= 2) ? 1'b0 : 1'b1;
        start    = (k == 4) ? 1'b1 : 1'b0;
      end
      step();
      check({tag, "_x"}, 32'(X), 32'(t[k]));
    end
    load_en  = 1'b0;
    load_bit = 1'b0;
    start    = 1'b0;
    mode     = 1'b1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_ones"}, 32'(ones_count), 32'(exp_ones));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_vec_wrap"}, 32'(sweep_vec), 32'd0);
    step();
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_ones_hold"}, 32'(ones_count), 32'(exp_ones));
    check({tag, "_x_hold"}, 32'(X), 32'(t[7]));
  endtask

  initial begin
    logic [7:0] xor3;
    xor3     = 8'b1001_0110;
    rst      = 1'b1;
    load_en  = 1'b0;
    load_bit = 1'b0;
    mode     = 1'b0;
    start    = 1'b0;
    in_vec   = 3'd0;
    step();
    step();
    rst = 1'b0;

    check("rst_x", 32'(X), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ones", 32'(ones_count), 32'd0);
    check("rst_vec", 32'(sweep_vec), 32'd0);

    live_all("live_zero", 8'h00);
    check("live_zero_busy", 32'(busy), 32'd0);
    check("live_zero_done", 32'(done), 32'd0);

    load_table(xor3);
    in_vec = 3'b111;
    step();
    check("xor_111", 32'(X), 32'd1);
    in_vec = 3'b011;
    step();
    check("xor_011", 32'(X), 32'd0);
    live_all("xor_live", xor3);

    run_sweep("sw_xor", xor3, 4'd4, 1'b0);

    // Sweep mode without start holds X.
    in_vec = 3'b001;
    step();
    step();
    check("hold_x", 32'(X), 32'd1);

    load_table(8'hFF);
    run_sweep("sw_ones", 8'hFF, 4'b1000, 1'b0);
    load_table(8'h00);
    run_sweep("sw_zero", 8'h00, 4'd0, 1'b0);

    // Load and start together: load wins, no sweep begins.
    load_table(8'h00);
    for (int i = 7; i >= 0; i--) begin
      load_en  = 1'b1;
      load_bit = xor3[i];
      mode     = 1'b1;
      start    = 1'b1;
      step();
      check("ld_beats_start", 32'(busy), 32'd0);
    end
    load_en = 1'b0;
    start   = 1'b0;
    live_all("ld_start_live", xor3);

    run_sweep("sw_dist", xor3, 4'd4, 1'b1);
    step();
    check("dist_no_extra_done", 32'(done), 32'd0);
    check("dist_no_restart", 32'(busy), 32'd0);
    live_all("dist_table", xor3);

    // Reset in the middle of a sweep.
    mode  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("mid_vec4", 32'(sweep_vec), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_x", 32'(X), 32'd0);
    check("mid_rst_ones", 32'(ones_count), 32'd0);
    check("mid_rst_vec", 32'(sweep_vec), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    mode   = 1'b0;
    in_vec = 3'b111;
    step();
    check("mid_rst_table", 32'(X), 32'd0);
    step();
    check("mid_rst_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_engine.md
# truth_table_engine

Parametrised, programmable N-input logic function with registered output. It is the successor to the fixed 3-input combinational lab function (inputs A, B, C; output X). The truth table is loaded serially at run time. The block operates in one of two modes: live evaluation of external inputs, or a self-driven exhaustive sweep of all 2^N_IN input combinations that counts the true minterms. It sits between lab-board switch inputs and the LED/scope output, and replaces hand-written stimulus sweeps.

## Interface
- N_IN, default 3 — number of logic inputs; legal range 1..6.
- DEPTH = 2^N_IN (derived, not overridable) — number of truth-table bits.
- clk  in  1  — single clock; all state updates on rising edge.
- rst  in  1  — synchronous, active-high reset.
- load_en  in  1  — shift one truth-table bit in this cycle.
- load_bit  in  1  — serial truth-table bit, first bit shifted = table[DEPTH-1].
- mode  in  1  — 0 = live evaluation, 1 = sweep enabled.
- start  in  1  — begin sweep (honoured only in IDLE with mode=1).
- in_vec  in  N_IN  — live inputs; bit 0 = A, bit 1 = B, bit 2 = C for N_IN=3.
- X  out  1  — registered function output.
- sweep_vec  out  N_IN  — input vector currently applied by the sweep.
- busy  out  1  — high in SWEEP and DONE.
- done  out  1  — one-cycle pulse at end of sweep.
- ones_count  out  N_IN+1  — number of true minterms found by the last sweep.

## Operation
- Reset: table=0, X=0, sweep_vec=0, busy=0, done=0, ones_count=0, state=IDLE.
- Load: in IDLE with load_en=1, table <= {table[DEPTH-2:0], load_bit}. After DEPTH shifts the table is fully replaced. While busy, load_en is ignored.
- Priority in IDLE: load_en beats start. If both are high, the bit shifts and start is dropped.
- Live (IDLE, mode=0): X <= table[in_vec] every cycle. There is no handshake.
- FSM states are IDLE, SWEEP and DONE.
  - IDLE→SWEEP: start=1, mode=1, load_en=0. sweep_vec <= 0 and ones_count <= 0.
  - In SWEEP, every cycle: X <= table[sweep_vec], ones_count += table[sweep_vec], sweep_vec += 1.
  - SWEEP→DONE: this happens in the cycle where sweep_vec==DEPTH-1 is evaluated. sweep_vec wraps to 0 and does not overflow into other bits.
  - DONE→IDLE: unconditional after one cycle. done=1 only in DONE.
- ones_count width is N_IN+1, so DEPTH (all-ones table) is representable without overflow. The value holds until the next start or reset.
- In SWEEP, mode and start changes are ignored. Clearing mode does not abort the sweep.
- In IDLE with mode=1 and no start, X holds its last value.
- Reset mid-sweep: IDLE in the next cycle, with all outputs at reset values and the table cleared.

## Timing
- Live latency: X reflects in_vec 1 cycle after sampling.
- Start sampled at edge t0:
  - SWEEP during cycles t0+1 … t0+DEPTH, with sweep_vec = 0 … DEPTH-1.
  - X for vector k is valid from edge t0+k+2.
  - DONE occurs in cycle t0+DEPTH+1, where X = table[DEPTH-1] and ones_count is final.
  - IDLE resumes at t0+DEPTH+2.
- The total sweep occupies DEPTH+1 busy cycles. Back-to-back sweeps need start again in IDLE, giving a minimum gap of 1 cycle.
- Full table load takes DEPTH cycles of load_en.

## Structure
- Package tte_pkg holds:
  - the state enum {IDLE, SWEEP, DONE};
  - the function computing DEPTH from N_IN;
  - the MODE_LIVE/MODE_SWEEP constants.
- Sub-module sweep_counter (N_IN-bit up-counter with clear, enable and terminal-count flag) is instantiated once. The table shift register and FSM stay in the top level.

## Test plan
- Reset then live mode with table 0: in_vec sweeps 0..7 → X stays 0; busy=0, done=0, ones_count=0.
- Load 8'b1001_0110 (XOR3, table[7] first), mode=0, in_vec=3'b111 → X=1 one cycle later; in_vec=3'b011 → X=0.
- Same table, mode=1, pulse start:
  - sweep_vec steps 0..7;
  - X sequence 0,1,1,0,1,0,0,1;
  - done pulses at start+9 cycles;
  - ones_count=4.
- Load all-ones table, sweep → ones_count=8 (4'b1000, no overflow); then all-zeros table, sweep → ones_count=0.
- During a sweep, drive load_en=1 with alternating load_bit, toggle mode to 0, and reassert start → the table is unchanged, the sweep completes normally, and exactly one done pulse occurs.
- Assert rst when sweep_vec=4 → the next cycle shows IDLE, X=0, busy=0, ones_count=0 and the table cleared, so a subsequent live evaluation gives X=0.
